// File: rtl/reg_script_monitor.sv
// reg_script_monitor: on-chip self-check engine for the Riscv151 core.
// Snoops the register-file writeback port into a shadow register file and
// runs a loadable script of WAIT / CHECK steps against it. It reports pass,
// fail and diagnostics without a simulator.
//
// Ports
//   clk, rst                    clock, synchronous active-high reset
//   wb_we/wb_addr/wb_data       snooped writeback port (x0 writes ignored)
//   cfg_we/cfg_addr/cfg_op/
//   cfg_reg/cfg_value           script entry write (IDLE or DONE only)
//   timeout_cycles              per-WAIT limit, 0 disables the timeout
//   start                       pulse: run the script from entry 0
//   busy, done, pass            run status (done and pass are sticky)
//   fail_step, fail_code,
//   got_value, err_count        failure diagnostics
//
// Optional build macro REG_MON_CONTINUE_EN: a CHECK mismatch is counted but
// does not stop the run. Only the first mismatch is recorded. Timeout and
// running off the end of the script remain fatal.
module reg_script_monitor #(
    parameter  int unsigned XLEN     = 32,
    parameter  int unsigned NUM_REGS = 32,
    parameter  int unsigned DEPTH    = 16,
    parameter  int unsigned TMO_W    = 24,
    localparam int unsigned RW       = $clog2(NUM_REGS),
    localparam int unsigned SW       = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wb_we,
    input  logic [RW-1:0]    wb_addr,
    input  logic [XLEN-1:0]  wb_data,
    input  logic             cfg_we,
    input  logic [SW-1:0]    cfg_addr,
    input  logic [1:0]       cfg_op,
    input  logic [RW-1:0]    cfg_reg,
    input  logic [XLEN-1:0]  cfg_value,
    input  logic [TMO_W-1:0] timeout_cycles,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [SW-1:0]    fail_step,
    output logic [1:0]       fail_code,
    output logic [XLEN-1:0]  got_value,
    output logic [7:0]       err_count
);

    localparam logic [1:0] OP_WAIT     = 2'd1;
    localparam logic [1:0] OP_CHECK    = 2'd2;
    localparam logic [1:0] FC_NONE     = 2'd0;
    localparam logic [1:0] FC_MISMATCH = 2'd1;
    localparam logic [1:0] FC_TIMEOUT  = 2'd2;
    localparam logic [1:0] FC_RUNOFF   = 2'd3;

    typedef struct packed {
        logic [1:0]      op;
        logic [RW-1:0]   rsel;
        logic [XLEN-1:0] value;
    } step_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_CHECK,
        S_DONE
    } state_t;

    state_t          state;
    logic [SW-1:0]   idx;
    logic [TMO_W-1:0] timer;
    step_t           script [DEPTH];
    logic [XLEN-1:0] shadow [NUM_REGS];

    step_t           cur_step_c;
    logic [XLEN-1:0] cur_val_c;
    logic            match_c;
    logic            last_step_c;
    logic            tmo_hit_c;
    logic            cfg_ok_c;
    logic            advance_c;

    // Current step and its compare against the registered shadow value.
    // There is no write-through bypass.
    assign cur_step_c  = script[idx];
    assign cur_val_c   = shadow[cur_step_c.rsel];
    assign match_c     = (cur_val_c == cur_step_c.value);
    assign last_step_c = (idx == SW'(DEPTH - 1));
    assign tmo_hit_c   = (timeout_cycles != '0) &&
                         (timer == timeout_cycles - TMO_W'(1));
    assign cfg_ok_c    = (state == S_IDLE) || (state == S_DONE);

    // Step completed and execution moves on to the next entry.
    always_comb begin
        advance_c = 1'b0;
        case (state)
            S_WAIT:  advance_c = match_c;
`ifdef REG_MON_CONTINUE_EN
            S_CHECK: advance_c = 1'b1;
`else
            S_CHECK: advance_c = match_c;
`endif
            default: advance_c = 1'b0;
        endcase
    end

    // Shadow register file. It snoops in every state and x0 is never written.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) shadow[i] <= '0;
        end else if (wb_we && (wb_addr != '0)) begin
            shadow[wb_addr] <= wb_data;
        end
    end

    // Script storage. Reset clears every entry to END.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) script[i] <= '0;
        end else if (cfg_we && cfg_ok_c) begin
            script[cfg_addr] <= '{op: cfg_op, rsel: cfg_reg, value: cfg_value};
        end
    end

    // Sequencer with registered status and diagnostics.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            idx       <= '0;
            timer     <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            fail_step <= '0;
            fail_code <= FC_NONE;
            got_value <= '0;
            err_count <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state     <= S_FETCH;
                        idx       <= '0;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        pass      <= 1'b0;
                        fail_step <= '0;
                        fail_code <= FC_NONE;
                        got_value <= '0;
                        err_count <= '0;
                    end
                end
                S_FETCH: begin
                    case (cur_step_c.op)
                        OP_WAIT: begin
                            timer <= '0;
                            state <= S_WAIT;
                        end
                        OP_CHECK: state <= S_CHECK;
                        default: begin
                            // END and the reserved opcode both terminate.
                            state <= S_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= (err_count == 8'd0);
                        end
                    endcase
                end
                S_WAIT: begin
                    if (!match_c) begin
                        timer <= timer + TMO_W'(1);
                        if (tmo_hit_c) begin
                            state     <= S_DONE;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            pass      <= 1'b0;
                            fail_step <= idx;
                            fail_code <= FC_TIMEOUT;
                            got_value <= cur_val_c;
                        end
                    end
                end
                S_CHECK: begin
                    if (!match_c) begin
                        if (err_count != 8'hFF) err_count <= err_count + 8'd1;
`ifdef REG_MON_CONTINUE_EN
                        // Keep the diagnostics of the first mismatch only.
                        if (err_count == 8'd0) begin
                            fail_step <= idx;
                            fail_code <= FC_MISMATCH;
                            got_value <= cur_val_c;
                        end
`else
                        fail_step <= idx;
                        fail_code <= FC_MISMATCH;
                        got_value <= cur_val_c;
                        state     <= S_DONE;
                        busy      <= 1'b0;
                        done      <= 1'b1;
                        pass      <= 1'b0;
`endif
                    end
                end
                default: state <= S_IDLE;
            endcase

            // Move to the next entry. Running past the last entry is fatal.
            if (advance_c) begin
                if (last_step_c) begin
                    state     <= S_DONE;
                    busy      <= 1'b0;
                    done      <= 1'b1;
                    pass      <= 1'b0;
                    fail_step <= idx;
                    fail_code <= FC_RUNOFF;
                end else begin
                    idx   <= idx + SW'(1);
                    state <= S_FETCH;
                end
            end
        end
    end

endmodule

// File: tb/tb_reg_script_monitor.sv
// Self-checking bench for reg_script_monitor. Expected run results are queued
// when a script is launched and compared when done rises.
module tb_reg_script_monitor;

    localparam int unsigned XLEN     = 32;
    localparam int unsigned NUM_REGS = 32;
    localparam int unsigned DEPTH    = 16;
    localparam int unsigned TMO_W    = 24;
    localparam int unsigned RW       = 5;
    localparam int unsigned SW       = 4;

    typedef struct packed {
        logic [1:0]      op;
        logic [RW-1:0]   rsel;
        logic [XLEN-1:0] value;
    } step_t;

    typedef struct packed {
        logic            pass;
        logic [1:0]      code;
        logic [SW-1:0]   step;
        logic [XLEN-1:0] got;
        logic [7:0]      err;
    } res_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             wb_we;
    logic [RW-1:0]    wb_addr;
    logic [XLEN-1:0]  wb_data;
    logic             cfg_we;
    logic [SW-1:0]    cfg_addr;
    logic [1:0]       cfg_op;
    logic [RW-1:0]    cfg_reg;
    logic [XLEN-1:0]  cfg_value;
    logic [TMO_W-1:0] timeout_cycles;
    logic             start;
    logic             busy;
    logic             done;
    logic             pass;
    logic [SW-1:0]    fail_step;
    logic [1:0]       fail_code;
    logic [XLEN-1:0]  got_value;
    logic [7:0]       err_count;

    step_t prog [DEPTH];
    res_t  sb [$];
    int    n_vec = 0;
    int    n_err = 0;

    always #5 clk = ~clk;

    reg_script_monitor #(
        .XLEN(XLEN), .NUM_REGS(NUM_REGS), .DEPTH(DEPTH), .TMO_W(TMO_W)
    ) dut (
        .clk(clk), .rst(rst),
        .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_op(cfg_op),
        .cfg_reg(cfg_reg), .cfg_value(cfg_value),
        .timeout_cycles(timeout_cycles), .start(start),
        .busy(busy), .done(done), .pass(pass),
        .fail_step(fail_step), .fail_code(fail_code),
        .got_value(got_value), .err_count(err_count)
    );

    function automatic string fmt(input res_t r);
        return $sformatf("pass=%0b code=%0d step=%0d got=%0d err=%0d",
                         r.pass, r.code, r.step, r.got, r.err);
    endfunction

    function automatic res_t mk(input logic p, input int c, input int s,
                                input int g, input int e);
        res_t r;
        r.pass = p;
        r.code = 2'(c);
        r.step = SW'(s);
        r.got  = XLEN'(g);
        r.err  = 8'(e);
        return r;
    endfunction

    task automatic clear_prog();
        for (int i = 0; i < DEPTH; i++) prog[i] = '0;
    endtask

    task automatic set_step(input int i, input int op, input int r, input int v);
        prog[i].op    = 2'(op);
        prog[i].rsel  = RW'(r);
        prog[i].value = XLEN'(v);
    endtask

    task automatic write_prog();
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            cfg_we    = 1'b1;
            cfg_addr  = SW'(i);
            cfg_op    = prog[i].op;
            cfg_reg   = prog[i].rsel;
            cfg_value = prog[i].value;
        end
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic wb_write(input int a, input int d);
        @(negedge clk);
        wb_we   = 1'b1;
        wb_addr = RW'(a);
        wb_data = XLEN'(d);
        @(negedge clk);
        wb_we = 1'b0;
    endtask

    // Returns 1 ns after the edge that samples start.
    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(input int budget, input string name, output res_t obs);
        int k = 0;
        while (done !== 1'b1 && k < budget) begin
            @(posedge clk);
            #1;
            k++;
        end
        if (done !== 1'b1) begin
            n_vec++;
            n_err++;
            $display("FAIL %s_done: done=%b after %0d cycles, want 1", name, done, budget);
        end
        obs = {pass, fail_code, fail_step, got_value, err_count};
    endtask

    task automatic test_reset();
        res_t obs;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_vec++;
        if ({busy, done} !== 2'b00) begin
            n_err++;
            $display("FAIL reset_busy_done: got %b want 00", {busy, done});
        end
        obs = {pass, fail_code, fail_step, got_value, err_count};
        n_vec++;
        if (obs !== '0) begin
            n_err++;
            $display("FAIL reset_diag: got %s want %s", fmt(obs), fmt('0));
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic_pass();
        res_t obs, e;
        clear_prog();
        set_step(0, 1, 20, 1);
        set_step(1, 2, 1, 300);
        set_step(2, 1, 20, 2);
        set_step(3, 2, 1, 500);
        set_step(4, 2, 2, 100);
        write_prog();
        timeout_cycles = '0;
        sb.push_back(mk(1'b1, 0, 0, 0, 0));
        pulse_start();
        n_vec++;
        if (busy !== 1'b1) begin
            n_err++;
            $display("FAIL basic_busy: got %b want 1", busy);
        end
        wb_write(1, 300);
        wb_write(20, 1);
        repeat (6) @(negedge clk);
        wb_write(1, 500);
        wb_write(2, 100);
        wb_write(20, 2);
        wait_done(100, "basic", obs);
        e = sb.pop_front();
        n_vec++;
        if (obs !== e) begin
            n_err++;
            $display("FAIL basic_result: got %s want %s", fmt(obs), fmt(e));
        end
    endtask

    // Reuses the script of test_basic_pass. x1 is wrong before x20 arrives.
    task automatic test_check_mismatch();
        res_t obs, e;
`ifdef REG_MON_CONTINUE_EN
        sb.push_back(mk(1'b0, 1, 1, 301, 2));
`else
        sb.push_back(mk(1'b0, 1, 1, 301, 1));
`endif
        pulse_start();
        wb_write(1, 301);
        wb_write(20, 1);
        repeat (6) @(negedge clk);
        wb_write(20, 2);
        wait_done(100, "mismatch", obs);
        e = sb.pop_front();
        n_vec++;
        if (obs !== e) begin
            n_err++;
            $display("FAIL mismatch_result: got %s want %s", fmt(obs), fmt(e));
        end
    endtask

    task automatic test_timeout();
        res_t obs, e;
        clear_prog();
        set_step(0, 1, 5, 7);
        write_prog();
        timeout_cycles = TMO_W'(100);
        sb.push_back(mk(1'b0, 2, 0, 0, 0));
        pulse_start();
        // FETCH after the start edge, then 100 WAIT cycles.
        repeat (100) @(posedge clk);
        #1;
        n_vec++;
        if (done !== 1'b0) begin
            n_err++;
            $display("FAIL timeout_early: done=%b at WAIT cycle 99, want 0", done);
        end
        @(posedge clk);
        #1;
        n_vec++;
        if (done !== 1'b1) begin
            n_err++;
            $display("FAIL timeout_exact: done=%b at WAIT cycle 100, want 1", done);
        end
        wait_done(5, "timeout", obs);
        e = sb.pop_front();
        n_vec++;
        if (obs !== e) begin
            n_err++;
            $display("FAIL timeout_result: got %s want %s", fmt(obs), fmt(e));
        end
        timeout_cycles = '0;
    endtask

    task automatic test_x0_same_cycle();
        res_t obs, e;
        wb_write(0, 55);
        clear_prog();
        set_step(0, 2, 0, 0);
        set_step(1, 1, 3, 9);
        write_prog();
        sb.push_back(mk(1'b1, 0, 0, 0, 0));
        pulse_start();
        @(posedge clk);
        @(posedge clk);
        // x3 lands on the edge that enters WAIT.
        @(negedge clk);
        wb_we   = 1'b1;
        wb_addr = RW'(3);
        wb_data = XLEN'(9);
        @(posedge clk);
        #1 wb_we = 1'b0;
        @(posedge clk);
        #1;
        n_vec++;
        if (done !== 1'b0) begin
            n_err++;
            $display("FAIL x0_early: done=%b one cycle after WAIT entry, want 0", done);
        end
        @(posedge clk);
        #1;
        n_vec++;
        if (done !== 1'b1) begin
            n_err++;
            $display("FAIL x0_latency: done=%b two cycles after WAIT entry, want 1", done);
        end
        wait_done(5, "x0", obs);
        e = sb.pop_front();
        n_vec++;
        if (obs !== e) begin
            n_err++;
            $display("FAIL x0_result: got %s want %s", fmt(obs), fmt(e));
        end
    endtask

    task automatic test_run_off_end();
        res_t obs, e;
        for (int i = 0; i < DEPTH; i++) set_step(i, 2, 0, 0);
        write_prog();
        sb.push_back(mk(1'b0, 3, DEPTH - 1, 0, 0));
        pulse_start();
        wait_done(100, "runoff", obs);
        e = sb.pop_front();
        n_vec++;
        if (obs !== e) begin
            n_err++;
            $display("FAIL runoff_result: got %s want %s", fmt(obs), fmt(e));
        end
    endtask

`ifdef REG_MON_CONTINUE_EN
    task automatic test_continue();
        res_t obs, e;
        wb_write(1, 11);
        wb_write(2, 22);
        wb_write(3, 33);
        clear_prog();
        set_step(0, 2, 1, 10);
        set_step(1, 2, 2, 22);
        set_step(2, 2, 3, 30);
        write_prog();
        sb.push_back(mk(1'b0, 1, 0, 11, 2));
        pulse_start();
        wait_done(50, "continue", obs);
        e = sb.pop_front();
        n_vec++;
        if (obs !== e) begin
            n_err++;
            $display("FAIL continue_result: got %s want %s", fmt(obs), fmt(e));
        end
    endtask
`endif

    task automatic test_rst_mid_run();
        res_t obs, e;
        clear_prog();
        set_step(0, 1, 7, 1);
        write_prog();
        timeout_cycles = '0;
        pulse_start();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_vec++;
        if ({busy, done} !== 2'b00) begin
            n_err++;
            $display("FAIL rst_mid_busy_done: got %b want 00", {busy, done});
        end
        @(negedge clk);
        rst = 1'b0;
        // Script is now all END: one FETCH, then DONE with pass.
        sb.push_back(mk(1'b1, 0, 0, 0, 0));
        pulse_start();
        n_vec++;
        if (done !== 1'b0) begin
            n_err++;
            $display("FAIL rst_mid_fetch: done=%b in FETCH, want 0", done);
        end
        @(posedge clk);
        #1;
        n_vec++;
        if ({done, pass} !== 2'b11) begin
            n_err++;
            $display("FAIL rst_mid_end: done,pass=%b want 11", {done, pass});
        end
        wait_done(5, "rst_mid", obs);
        e = sb.pop_front();
        n_vec++;
        if (obs !== e) begin
            n_err++;
            $display("FAIL rst_mid_result: got %s want %s", fmt(obs), fmt(e));
        end
    endtask

    initial begin
        rst            = 1'b1;
        wb_we          = 1'b0;
        wb_addr        = '0;
        wb_data        = '0;
        cfg_we         = 1'b0;
        cfg_addr       = '0;
        cfg_op         = '0;
        cfg_reg        = '0;
        cfg_value      = '0;
        timeout_cycles = '0;
        start          = 1'b0;
        clear_prog();

        test_reset();
        test_basic_pass();
        test_check_mismatch();
        test_timeout();
        test_x0_same_cycle();
        test_run_off_end();
`ifdef REG_MON_CONTINUE_EN
        test_continue();
`endif
        test_rst_mid_run();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
